// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Multi-master memory bus front end. Arbitrates NUM_MASTERS
//               requestors onto one registered memory port (IDLE/ACCESS/RESP).
//               Define ARB_ROUND_ROBIN_EN for round-robin arbitration;
//               otherwise fixed priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_MASTERS = 2,
    parameter int IDW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*WIDTH-1:0]      m_wdata,
    input  logic [NUM_MASTERS*(WIDTH/8)-1:0]  m_byteen,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [WIDTH-1:0]                  m_rdata,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [WIDTH-1:0]                  mem_wdata,
    output logic [WIDTH/8-1:0]                mem_byteen,
    input  logic [WIDTH-1:0]                  mem_rdata,
    input  logic                              mem_ready,
    output logic [IDW-1:0]                    grant_id,
    output logic                              busy
);

    localparam int c_be_w = WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]        r_wdata;
    logic [c_be_w-1:0]       r_byteen;
    logic [IDW-1:0]          r_grant_id;
    logic [WIDTH-1:0]        r_rdata;

    logic                    w_grant_valid;
    logic [IDW-1:0]          w_grant_idx;
    int                      w_idx;

    logic                    w_we_arr     [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0]   w_addr_arr   [NUM_MASTERS];
    logic [WIDTH-1:0]        w_wdata_arr  [NUM_MASTERS];
    logic [c_be_w-1:0]       w_byteen_arr [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign w_we_arr[i]     = m_we[i];
        assign w_addr_arr[i]   = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[i]  = m_wdata[i*WIDTH +: WIDTH];
        assign w_byteen_arr[i] = m_byteen[i*c_be_w +: c_be_w];
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] r_ptr;

    // Scan from highest offset down so the closest-after-pointer requester wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_idx         = 0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + 1 + k) % NUM_MASTERS;
            if (m_req[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = IDW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= IDW'(NUM_MASTERS - 1);
        end else if (r_state == S_IDLE && w_grant_valid) begin
            r_ptr <= w_grant_idx;
        end
    end
`else
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_idx         = 0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            w_idx = k;
            if (m_req[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = IDW'(w_idx);
            end
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_valid) w_state_next = S_ACCESS;
            S_ACCESS: if (mem_ready)     w_state_next = S_RESP;
            S_RESP:                      w_state_next = S_IDLE;
            default:                     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_byteen   <= '0;
            r_grant_id <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && w_grant_valid) begin
                r_we       <= w_we_arr[w_grant_idx];
                r_addr     <= w_addr_arr[w_grant_idx];
                r_wdata    <= w_wdata_arr[w_grant_idx];
                r_byteen   <= w_byteen_arr[w_grant_idx];
                r_grant_id <= w_grant_idx;
            end
            if (r_state == S_ACCESS && mem_ready && !r_we) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Strobes decode from state so an async reset drops them immediately.
    assign mem_read   = (r_state == S_ACCESS) && !r_we;
    assign mem_write  = (r_state == S_ACCESS) &&  r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_byteen = r_byteen;
    assign m_rdata    = r_rdata;
    assign grant_id   = r_grant_id;
    assign busy       = (r_state != S_IDLE);

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_ack
        assign m_ack[i] = (r_state == S_RESP) && (r_grant_id == IDW'(i));
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised multi-master memory bus front end for the multicycle RISC-V core. It accepts word/byte read and write requests from `NUM_MASTERS` requestors, such as instruction fetch, data load/store and a debug port. It serialises them onto one memory port through a registered request/ready handshake with variable memory latency. It sits between `riscv_mc_core` and `memory_bus`, replacing the direct single-master connection with arbitrated, stall-tolerant access.

## Interface
- `WIDTH`, 32: data width; must be a multiple of 8.
- `ADDR_WIDTH`, 32: address width.
- `NUM_MASTERS`, 2: number of requestors, ≥1.
- `IDW`, derived, max(1, $clog2(NUM_MASTERS)): grant index width.
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m_req`  in  NUM_MASTERS  per-master request, level.
- `m_we`  in  NUM_MASTERS  1 = write, 0 = read.
- `m_addr`  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at slice i.
- `m_wdata`  in  NUM_MASTERS*WIDTH  packed write data.
- `m_byteen`  in  NUM_MASTERS*(WIDTH/8)  packed byte enables.
- `m_ack`  out  NUM_MASTERS  one-hot, one-cycle completion pulse.
- `m_rdata`  out  WIDTH  shared read data; valid only while the corresponding `m_ack` bit is high.
- `mem_read`, `mem_write`  out  1 each  memory strobes; never both high.
- `mem_addr`  out  ADDR_WIDTH; `mem_wdata`  out  WIDTH; `mem_byteen`  out  WIDTH/8.
- `mem_rdata`  in  WIDTH  memory read data, sampled with `mem_ready`.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `grant_id`  out  IDW  index of the master owning the current or last transaction.
- `busy`  out  1  high in ACCESS and RESP.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any `m_req` bit is high, pick a winner per the arbitration policy.
  - Register the winner's `we`/`addr`/`wdata`/`byteen` and set `grant_id`.
  - Next state is ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Drive `mem_read = ~we_q` and `mem_write = we_q` from registers. `mem_addr`, `mem_wdata` and `mem_byteen` come from registers and are held stable.
  - When `mem_ready` = 1: capture `mem_rdata` (reads only; writes leave `m_rdata` unchanged), then go to RESP.
  - Stall indefinitely while `mem_ready` = 0.
- RESP:
  - `m_ack[grant_id]` = 1 for exactly this cycle; `m_rdata` holds the captured data.
  - `m_req` is ignored in this state.
  - Next state is IDLE.
- Master contract:
  - Hold `m_req` and its payload stable from assertion until its `m_ack`.
  - `m_req` still high in the cycle after `m_ack` is treated as a new request.
- Payload changes after the request is granted (registered) have no effect on the transaction.
- `mem_ready` is ignored outside ACCESS.
- Non-granted masters keep waiting; they receive no ack.

## Timing
- Reset values (immediate, asynchronous):
  - State IDLE.
  - `m_ack` = 0, `m_rdata` = 0.
  - `mem_read` = `mem_write` = 0; `mem_addr`/`mem_wdata`/`mem_byteen` = 0.
  - `grant_id` = 0, `busy` = 0, round-robin pointer = NUM_MASTERS-1.
- Reset mid-transaction:
  - Strobes drop asynchronously and the transaction is abandoned with no ack.
  - The first post-reset arbitration uses reset priority.
- Timeline, with request sampled at edge 0 and memory latency L ≥ 1 ACCESS cycles:
  - Strobes high during cycles 1..L.
  - `m_ack` high in cycle L+1.
  - IDLE in cycle L+2.
- Minimum service time is 3 cycles; back-to-back peak is one transaction per 3 cycles.
- `NUM_MASTERS` = 1: arbitration is trivial and `grant_id` stays 0.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Priority starts at (last granted + 1) mod NUM_MASTERS, searching upward with wrap-around.
  - The pointer updates on each grant.
  - After reset, master 0 has top priority.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority; the lowest index wins.
  - No pointer register exists.
  - Higher-index masters may starve; this is the documented behaviour.

## Test plan
- Single read: master 0 reads addr 0x100 and memory returns 0xDEADBEEF with `mem_ready` in the first ACCESS cycle. Required: `mem_read` high for 1 cycle, `m_ack` = 2'b01 two cycles after sampling, `m_rdata` = 0xDEADBEEF.
- Write with stall: master 1 writes 0x12345678 to 0x200 with byteen 4'b0011, and `mem_ready` is held low for 3 cycles. Required: strobe and payload stable for 4 cycles, then `m_ack` = 2'b10 with `grant_id` = 1.
- Contention (round-robin enabled): both masters hold `m_req` continuously. Required: grants alternate 0, 1, 0, 1, and each master is acked every 6 cycles.
- Contention (macro undefined), same stimulus. Required: master 0 is acked every 3 cycles and master 1 is never acked.
- Reset mid-access: assert `reset` low during ACCESS. Required: strobes drop in the same cycle, no `m_ack`, all outputs zero; after release, a master 1 request completes normally.
- Payload change: master 0 alters `m_addr` after the grant. Required: `mem_addr` keeps the originally registered address until ack.
